// File: rtl/store_buffer.sv
// In-order store buffer ahead of the data-cache bank write port.
// Merges same-word stores into the youngest entry and forwards buffered bytes to loads.
module store_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_address_i,
  input  logic [31:0]           push_data_i,
  input  logic [3:0]            push_byte_i,
  output logic                  push_ready_o,
  output logic                  write_o,
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [31:0]           write_data_o,
  output logic [3:0]            byte_write_o,
  input  logic                  write_grant_i,
  input  logic [ADDR_WIDTH-1:0] fwd_address_i,
  output logic                  fwd_hit_o,
  output logic [31:0]           fwd_data_o,
  output logic [3:0]            fwd_byte_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LANES  = 4;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [31:0]           r_data [DEPTH];
  logic [LANES-1:0]      r_mask [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic [PTR_W-1:0]      w_young;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_merge_ok;
  logic                  w_merge;
  logic                  w_alloc;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_fwd_hit;
  logic [31:0]           w_fwd_data;
  logic [LANES-1:0]      w_fwd_byte;

  assign w_young = r_tail - PTR_W'(1);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = !w_empty && write_grant_i;

  // Merging into an entry that is leaving this cycle would lose the new bytes.
  assign w_merge_ok = !w_empty && (push_address_i == r_addr[w_young])
                      && !((w_young == r_head) && w_pop);
  assign w_merge    = push_i && w_merge_ok;
  assign w_alloc    = push_i && !w_merge_ok && !w_full;

  assign push_ready_o    = w_merge_ok || !w_full;
  assign write_o         = !w_empty;
  assign write_address_o = r_addr[r_head];
  assign write_data_o    = r_data[r_head];
  assign byte_write_o    = r_mask[r_head];
  assign empty_o         = w_empty;
  assign full_o          = w_full;
  assign fwd_hit_o       = w_fwd_hit;
  assign fwd_data_o      = w_fwd_data;
  assign fwd_byte_o      = w_fwd_byte;

  // Walk oldest to youngest so younger matching lanes overwrite older ones.
  always_comb begin
    w_idx      = r_head;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_byte = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (r_valid[w_idx] && (r_addr[w_idx] == fwd_address_i)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_byte = w_fwd_byte | r_mask[w_idx];
        for (int b = 0; b < LANES; b++) begin
          if (r_mask[w_idx][b]) begin
            w_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_merge) begin
        for (int b = 0; b < LANES; b++) begin
          if (push_byte_i[b]) begin
            r_data[w_young][8*b +: 8] <= push_data_i[8*b +: 8];
          end
        end
        r_mask[w_young] <= r_mask[w_young] | push_byte_i;
      end else if (w_alloc) begin
        r_addr[r_tail]  <= push_address_i;
        r_data[r_tail]  <= push_data_i;
        r_mask[r_tail]  <= push_byte_i;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer: a table of per-cycle stimulus and
// expected outputs, plus short hand-written sequences for pop/push corner cases.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        push;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_be;
  logic        push_ready;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        grant;
  logic [31:0] faddr;
  logic        fhit;
  logic [31:0] fdata;
  logic [3:0]  fbe;
  logic        empty;
  logic        full;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .push_i          (push),
    .push_address_i  (push_addr),
    .push_data_i     (push_data),
    .push_byte_i     (push_be),
    .push_ready_o    (push_ready),
    .write_o         (wr),
    .write_address_o (waddr),
    .write_data_o    (wdata),
    .byte_write_o    (wbe),
    .write_grant_i   (grant),
    .fwd_address_i   (faddr),
    .fwd_hit_o       (fhit),
    .fwd_data_o      (fdata),
    .fwd_byte_o      (fbe),
    .empty_o         (empty),
    .full_o          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic        rst;
    logic        push;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        grant;
    logic [31:0] faddr;
    logic        e_wr;
    logic [31:0] e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wbe;
    logic        e_rdy;
    logic        e_empty;
    logic        e_full;
    logic        e_hit;
    logic [3:0]  e_fbe;
    logic [31:0] e_fdata;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(bit c, logic r, logic p, logic [31:0] a, logic [31:0] d,
                              logic [3:0] b, logic g, logic [31:0] fa,
                              logic ew, logic [31:0] ewa, logic [31:0] ewd, logic [3:0] ewb,
                              logic erdy, logic eemp, logic efull,
                              logic ehit, logic [3:0] efb, logic [31:0] efd);
    vec_t v;
    v.chk = c; v.rst = r; v.push = p; v.addr = a; v.data = d; v.be = b; v.grant = g;
    v.faddr = fa; v.e_wr = ew; v.e_waddr = ewa; v.e_wdata = ewd; v.e_wbe = ewb;
    v.e_rdy = erdy; v.e_empty = eemp; v.e_full = efull;
    v.e_hit = ehit; v.e_fbe = efb; v.e_fdata = efd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic g, input logic [31:0] fa);
    rst = r; push = p; push_addr = a; push_data = d; push_be = b; grant = g; faddr = fa;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    //            chk rst psh addr   data          be   gnt faddr  | wr waddr  wdata         wbe  rdy emp ful hit fbe  fdata
    vecs[0]  = mk(0, 1, 0, 32'h00, 32'h00000000, 4'h0, 0, 32'h00,  0, 32'h00, 32'h00000000, 4'h0, 1, 1, 0, 0, 4'h0, 32'h00000000);
    vecs[1]  = mk(1, 0, 1, 32'h10, 32'hAABBCCDD, 4'hF, 0, 32'h10,  0, 32'h00, 32'h00000000, 4'h0, 1, 1, 0, 0, 4'h0, 32'h00000000);
    vecs[2]  = mk(1, 0, 0, 32'h00, 32'h00000000, 4'h0, 1, 32'h10,  1, 32'h10, 32'hAABBCCDD, 4'hF, 1, 0, 0, 1, 4'hF, 32'hAABBCCDD);
    vecs[3]  = mk(1, 0, 1, 32'h20, 32'h00000011, 4'h1, 0, 32'h20,  0, 32'h00, 32'h00000000, 4'h0, 1, 1, 0, 0, 4'h0, 32'h00000000);
    vecs[4]  = mk(1, 0, 1, 32'h20, 32'h00330000, 4'h4, 0, 32'h20,  1, 32'h20, 32'h00000011, 4'h1, 1, 0, 0, 1, 4'h1, 32'h00000011);
    vecs[5]  = mk(1, 0, 0, 32'h00, 32'h00000000, 4'h0, 1, 32'h20,  1, 32'h20, 32'h00330011, 4'h5, 1, 0, 0, 1, 4'h5, 32'h00330011);
    vecs[6]  = mk(1, 0, 1, 32'h30, 32'h000000AA, 4'h1, 0, 32'h30,  0, 32'h00, 32'h00000000, 4'h0, 1, 1, 0, 0, 4'h0, 32'h00000000);
    vecs[7]  = mk(1, 0, 1, 32'h40, 32'h12345678, 4'hF, 0, 32'h30,  1, 32'h30, 32'h000000AA, 4'h1, 1, 0, 0, 1, 4'h1, 32'h000000AA);
    vecs[8]  = mk(1, 0, 1, 32'h30, 32'h0000BB00, 4'h2, 0, 32'h30,  1, 32'h30, 32'h000000AA, 4'h1, 1, 0, 0, 1, 4'h1, 32'h000000AA);
    vecs[9]  = mk(1, 0, 0, 32'h30, 32'h00000000, 4'h0, 0, 32'h30,  1, 32'h30, 32'h000000AA, 4'h1, 1, 0, 0, 1, 4'h3, 32'h0000BBAA);
    vecs[10] = mk(1, 0, 1, 32'h50, 32'h00000055, 4'h1, 0, 32'h40,  1, 32'h30, 32'h000000AA, 4'h1, 1, 0, 0, 1, 4'hF, 32'h12345678);
    vecs[11] = mk(1, 0, 1, 32'h60, 32'h00000066, 4'h1, 0, 32'h50,  1, 32'h30, 32'h000000AA, 4'h1, 0, 0, 1, 1, 4'h1, 32'h00000055);
    vecs[12] = mk(1, 0, 1, 32'h50, 32'h0000EE00, 4'h2, 0, 32'h60,  1, 32'h30, 32'h000000AA, 4'h1, 1, 0, 1, 0, 4'h0, 32'h00000000);
    vecs[13] = mk(1, 0, 1, 32'h60, 32'h00000066, 4'h1, 1, 32'h50,  1, 32'h30, 32'h000000AA, 4'h1, 0, 0, 1, 1, 4'h3, 32'h0000EE55);
    vecs[14] = mk(1, 0, 1, 32'h60, 32'h00000066, 4'h1, 0, 32'h60,  1, 32'h40, 32'h12345678, 4'hF, 1, 0, 0, 0, 4'h0, 32'h00000000);
    vecs[15] = mk(1, 0, 1, 32'h60, 32'h00006600, 4'h2, 1, 32'h60,  1, 32'h40, 32'h12345678, 4'hF, 1, 0, 1, 1, 4'h1, 32'h00000066);
    vecs[16] = mk(1, 0, 1, 32'h70, 32'h77000000, 4'h8, 1, 32'h30,  1, 32'h30, 32'h0000BB00, 4'h2, 1, 0, 0, 1, 4'h2, 32'h0000BB00);
    vecs[17] = mk(1, 1, 1, 32'h80, 32'h88888888, 4'hF, 1, 32'h60,  1, 32'h50, 32'h0000EE55, 4'h3, 1, 0, 0, 1, 4'h3, 32'h00006666);
    vecs[18] = mk(1, 0, 0, 32'h00, 32'h00000000, 4'h0, 0, 32'h60,  0, 32'h00, 32'h00000000, 4'h0, 1, 1, 0, 0, 4'h0, 32'h00000000);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].push, vecs[i].addr, vecs[i].data, vecs[i].be,
            vecs[i].grant, vecs[i].faddr);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d write_o", i),      32'(wr),         32'(vecs[i].e_wr));
        check($sformatf("v%0d push_ready", i),   32'(push_ready), 32'(vecs[i].e_rdy));
        check($sformatf("v%0d empty", i),        32'(empty),      32'(vecs[i].e_empty));
        check($sformatf("v%0d full", i),         32'(full),       32'(vecs[i].e_full));
        check($sformatf("v%0d fwd_hit", i),      32'(fhit),       32'(vecs[i].e_hit));
        check($sformatf("v%0d fwd_byte", i),     32'(fbe),        32'(vecs[i].e_fbe));
        check($sformatf("v%0d fwd_data", i),     fdata,           vecs[i].e_fdata);
        if (vecs[i].e_wr) begin
          check($sformatf("v%0d write_addr", i), waddr,           vecs[i].e_waddr);
          check($sformatf("v%0d write_data", i), wdata,           vecs[i].e_wdata);
          check($sformatf("v%0d byte_write", i), 32'(wbe),        32'(vecs[i].e_wbe));
        end
      end
      @(posedge clk);
    end

    // Push to the sole entry while it is being granted: must allocate, not merge.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h90, 32'h11111111, 4'hF, 1'b0, 32'h90);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h90, 32'h22222222, 4'hF, 1'b1, 32'h90);
    #1;
    check("pp ready",       32'(push_ready), 32'd1);
    check("pp drain data",  wdata,           32'h11111111);
    check("pp drain mask",  32'(wbe),        32'hF);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h90);
    #1;
    check("pp write_o",     32'(wr),         32'd1);
    check("pp new data",    wdata,           32'h22222222);
    check("pp fwd data",    fdata,           32'h22222222);
    check("pp full",        32'(full),       32'd0);

    // Zero byte-enable store still allocates an entry with an empty mask.
    drive(1'b0, 1'b1, 32'hA0, 32'hDEADBEEF, 4'h0, 1'b1, 32'hA0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA0);
    #1;
    check("z0 write_o",     32'(wr),         32'd1);
    check("z0 write_addr",  waddr,           32'hA0);
    check("z0 byte_write",  32'(wbe),        32'h0);
    check("z0 fwd_hit",     32'(fhit),       32'd1);
    check("z0 fwd_byte",    32'(fbe),        32'h0);
    check("z0 fwd_data",    fdata,           32'h0);
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    #1;
    check("z0 empty",       32'(empty),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side staging queue placed directly upstream of the data cache data bank's write port. Accepts byte-masked stores from the load/store unit and holds them in a small in-order FIFO. Merges a store into the youngest entry when both target the same word, and drains one entry per granted cycle into the bank. Also provides same-cycle store-to-load forwarding, so a load on the bank read port never returns data older than a buffered store.

## Interface
- ADDR_WIDTH, 32, word address width; equals the bank's address width.
- DEPTH, 4, number of entries; power of two, at least 2.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- push_i  in  1  store request from the LSU.
- push_address_i  in  ADDR_WIDTH  word address of the store.
- push_data_i  in  32 (data_word_t)  store data, byte-lane aligned.
- push_byte_i  in  4  byte enables; bit i covers data[8i+7:8i].
- push_ready_o  out  1  store is accepted this cycle if push_i=1.
- write_o  out  1  head entry valid; drives the bank write_i.
- write_address_o  out  ADDR_WIDTH  head address.
- write_data_o  out  32  head data.
- byte_write_o  out  4  head byte enables.
- write_grant_i  in  1  bank consumes the head this cycle.
- fwd_address_i  in  ADDR_WIDTH  load word address to check.
- fwd_hit_o  out  1  at least one valid entry matches fwd_address_i.
- fwd_data_o  out  32  forwarded bytes; lanes not in fwd_byte_o are 0.
- fwd_byte_o  out  4  lanes supplied by the buffer.
- empty_o  out  1  no valid entries.
- full_o  out  1  DEPTH valid entries.

## Operation
- Storage: DEPTH entries of {address, data, byte mask}. Each entry has a valid bit. Pointers: head, tail (log2 DEPTH bits, wrapping modulo DEPTH) and count (log2 DEPTH + 1 bits).
- Drain: write_o = !empty_o. Head fields drive the write_* outputs combinationally from registers. The head pops when write_o & write_grant_i.
- Merge condition (all must hold):
  - push_i=1 and the buffer is non-empty.
  - push_address_i equals the address of the youngest entry (tail-1).
  - That entry is not the head being popped this cycle.
- Merge action: for each lane with push_byte_i set, overwrite the entry's data lane and set its mask bit. Other lanes are unchanged. Count is unchanged.
- Allocate: if push_i=1 and the merge condition fails, write a new entry at tail, then tail+1 and count+1. Allocation is allowed only when !full_o.
- push_ready_o = merge condition | !full_o. Combinational; it does not depend on push_i.
- A push with push_ready_o=0 is dropped, and the LSU must hold it. A push on a full buffer is not accepted even if a pop happens in the same cycle.
- Simultaneous allocate and pop: count is unchanged, both pointers advance.
- Merge while full is legal; count stays at DEPTH.
- Forwarding:
  - Compare fwd_address_i against all valid entries.
  - Per lane, the youngest matching entry that has that lane's mask bit set supplies the byte.
  - fwd_byte_o is the OR of the matching masks. fwd_hit_o = |matches.
  - Purely combinational on the registered state. A push in the same cycle is not visible.
- push_byte_i=4'b0000 is treated as a normal store: it allocates or merges with no data change.

## Timing
- Reset state, one cycle after rst_i sampled high: head=tail=count=0; all valid bits cleared; write_o=0, empty_o=1, full_o=0, push_ready_o=1, fwd_hit_o=0, fwd_byte_o=0, fwd_data_o=0. Entry data contents are don't-care.
- Reset mid-operation discards all pending stores. It dominates a push or grant in the same cycle.
- Push-to-drain latency: 1 cycle. A store pushed at edge N appears on write_* after edge N and can be granted in cycle N+1.
- Push-to-forward latency: 1 cycle, the same visibility as drain.
- Throughput: one accept and one drain per cycle, sustained.
- write_* outputs are stable while write_o=1 and write_grant_i=0, except for byte lanes/mask growing through a merge when head==tail.
- empty_o/full_o are derived from count after the edge; they are not look-ahead.

## Test plan
- Reset, then push {addr=0x10, data=0xAABBCCDD, byte=4'hF} -> next cycle write_o=1, write_address_o=0x10, byte_write_o=4'hF; grant for one cycle -> empty_o=1.
- Push addr 0x20 byte=4'h1 data=0x11, then addr 0x20 byte=4'h4 data=0x00330000, no grant -> single entry, count=1, data lanes 0x00330011, byte_write_o=4'h5.
- Push 4 distinct addresses with grant=0 -> full_o=1, push_ready_o=0 for a new address, a 5th push is dropped, push_ready_o=1 for a push to the youngest address (merge).
- Entries A:{0x30, 0x000000AA, 4'h1} then B:{0x40, ...} then C:{0x30, 0x0000BB00, 4'h2}; fwd_address_i=0x30 -> fwd_hit_o=1, fwd_byte_o=4'h3, fwd_data_o=0x0000BBAA.
- One entry at head=tail, push to the same address with grant=1 in the same cycle -> no merge, new entry allocated, the old entry is drained with its original data.
- Buffer holding 3 entries, assert rst_i for one cycle together with push_i and write_grant_i -> empty_o=1, write_o=0, fwd_hit_o=0 the next cycle.
